// File: rtl/leaf_cluster_bridge.sv
// rtl/leaf_cluster_bridge.sv - N-channel bridge between BFT leaf ports and leaf operators
// Per channel: inbound FIFO with resend-on-overflow, outbound one-packet replay, run-control FSM.
module leaf_cluster_bridge #(
  parameter int NUM_LEAF   = 4,
  parameter int PKT_W      = 49,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_LEAF-1:0]       ap_start,
  input  logic [NUM_LEAF*PKT_W-1:0] din_leaf_bft2interface,
  output logic [NUM_LEAF-1:0]       resend_to_bft,
  output logic [NUM_LEAF*PKT_W-1:0] dout_leaf_interface2bft,
  input  logic [NUM_LEAF-1:0]       resend_from_bft,
  output logic [NUM_LEAF*PKT_W-1:0] leaf_in_pkt,
  input  logic [NUM_LEAF-1:0]       leaf_in_ready,
  input  logic [NUM_LEAF*PKT_W-1:0] leaf_out_pkt,
  output logic [NUM_LEAF-1:0]       leaf_out_ready,
  output logic [NUM_LEAF*2-1:0]     run_state,
  output logic [NUM_LEAF*CNT_W-1:0] drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = PKT_W - 1;
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DROP_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } run_t;

  typedef enum logic [1:0] {
    R_EMPTY   = 2'd0,
    R_PRESENT = 2'd1,
    R_VERIFY  = 2'd2
  } rep_t;

  for (genvar c = 0; c < NUM_LEAF; c++) begin : g_ch
    logic [PKT_W-1:0] din;
    logic [PKT_W-1:0] lout;
    logic [DW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] drops;
    logic             resend_q;
    run_t             state;
    rep_t             rep;
    logic [DW-1:0]    rep_data;

    logic empty, full, in_valid, pop, push_req, push_ok, drop;
    logic rep_done, out_ready, accept;

    assign din      = din_leaf_bft2interface[c*PKT_W +: PKT_W];
    assign lout     = leaf_out_pkt[c*PKT_W +: PKT_W];

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign in_valid = (state != S_IDLE) && !empty;
    assign pop      = in_valid && leaf_in_ready[c];
    assign push_req = din[PKT_W-1];
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // The replay slot frees in the verify cycle when the BFT did not bounce it.
    assign rep_done  = (rep == R_VERIFY) && !resend_from_bft[c];
    assign out_ready = (state == S_RUN) && ((rep == R_EMPTY) || rep_done);
    assign accept    = out_ready && lout[PKT_W-1];

    assign leaf_in_pkt[c*PKT_W +: PKT_W]             = in_valid ? {1'b1, mem[rd_ptr]} : '0;
    assign dout_leaf_interface2bft[c*PKT_W +: PKT_W] = (rep == R_PRESENT) ? {1'b1, rep_data} : '0;
    assign leaf_out_ready[c]                         = out_ready;
    assign resend_to_bft[c]                          = resend_q;
    assign run_state[c*2 +: 2]                       = state;
    assign drop_cnt[c*CNT_W +: CNT_W]                = drops;

    always_ff @(posedge clk) begin
      if (push_ok) begin
        mem[wr_ptr] <= din[DW-1:0];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        drops    <= '0;
        resend_q <= 1'b0;
      end else begin
        resend_q <= drop;
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
        if (drop && (drops != '1)) begin
          drops <= drops + DROP_ONE;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rep      <= R_EMPTY;
        rep_data <= '0;
      end else begin
        case (rep)
          R_EMPTY: begin
            if (accept) begin
              rep_data <= lout[DW-1:0];
              rep      <= R_PRESENT;
            end
          end
          R_PRESENT: rep <= R_VERIFY;
          R_VERIFY: begin
            if (resend_from_bft[c]) begin
              rep <= R_PRESENT;
            end else if (accept) begin
              rep_data <= lout[DW-1:0];
              rep      <= R_PRESENT;
            end else begin
              rep <= R_EMPTY;
            end
          end
          default: rep <= R_EMPTY;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE:  if (ap_start[c]) state <= S_RUN;
          S_RUN:   if (!ap_start[c]) state <= S_FLUSH;
          S_FLUSH: begin
            if (ap_start[c]) begin
              state <= S_RUN;
            end else if (empty && (rep == R_EMPTY)) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/leaf_cluster_bridge.md
Name: leaf_cluster_bridge

Overview:
- Parametrised N-channel leaf cluster interface between BFT leaf ports and leaf operators.
- Successor to the fixed four-channel black-box leaf grouping.
- Per channel:
  - Inbound: BFT packets are buffered in a FIFO. On overflow the bridge requests a resend.
  - Outbound: leaf packets are presented to the BFT with a one-packet replay register.
  - Run control: a state machine gated by ap_start.
- All channels share one clock; channels are otherwise independent.

Parameters:
NUM_LEAF, 4, number of leaf channels (1..16)
PKT_W, 49, packet width; bit PKT_W-1 is the valid flag, bits PKT_W-2:0 are addr+payload
FIFO_DEPTH, 8, inbound FIFO entries per channel; power of two, >=2
CNT_W, 16, width of per-channel saturating drop counter

Ports:
clk  input  1  sole clock, rising edge
reset_n  input  1  asynchronous active-low reset
ap_start  input  NUM_LEAF  per-channel run request, level
din_leaf_bft2interface  input  NUM_LEAF*PKT_W  inbound packets from BFT, channel c at [c*PKT_W +: PKT_W]
resend_to_bft  output  NUM_LEAF  request BFT to resend the packet it offered last cycle
dout_leaf_interface2bft  output  NUM_LEAF*PKT_W  outbound packets to BFT
resend_from_bft  input  NUM_LEAF  BFT rejected the packet presented on the previous cycle
leaf_in_pkt  output  NUM_LEAF*PKT_W  head of inbound FIFO to leaf; valid bit set when deliverable
leaf_in_ready  input  NUM_LEAF  leaf consumes leaf_in_pkt this cycle when valid
leaf_out_pkt  input  NUM_LEAF*PKT_W  outbound packet from leaf; valid bit = offer
leaf_out_ready  output  NUM_LEAF  bridge accepts leaf_out_pkt this cycle when valid
run_state  output  NUM_LEAF*2  per-channel state: 0 IDLE, 1 RUN, 2 FLUSH
drop_cnt  output  NUM_LEAF*CNT_W  per-channel count of inbound overflow events, saturating

Behaviour:
- Reset (reset_n=0, async):
  - All FIFOs empty, replay registers empty, states IDLE, drop_cnt 0.
  - resend_to_bft, dout, leaf_in_pkt and leaf_out_ready all 0.
- Inbound write, channel c:
  - When din valid bit is 1 and FIFO count < FIFO_DEPTH: write on this edge.
  - When the FIFO is full: drop the packet; resend_to_bft[c]=1 on the next cycle only (registered, one cycle per dropped packet); drop_cnt[c]+1, saturating at 2^CNT_W-1.
  - Writes occur in every state, including IDLE.
- Inbound read:
  - leaf_in_pkt = FIFO head, with valid bit = (state!=IDLE && !empty), combinational from registers.
  - Pop on valid && leaf_in_ready.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, so the push is accepted and no resend is raised.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Outbound, two-phase per packet:
  - leaf_out_ready[c] = (state==RUN && replay empty).
  - Accept: the packet is loaded into the replay register. It is driven on dout for exactly one cycle (P) starting the next cycle.
  - Cycle after P (V): dout valid bit 0; sample resend_from_bft[c].
    - 1: re-present on the following cycle, then repeat V.
    - 0: replay register empties; leaf_out_ready may rise in this same V cycle.
  - Peak rate is one packet per 2 cycles.
  - resend_from_bft in a P cycle is ignored.
- State machine, per channel:
  - IDLE -> RUN when ap_start[c]=1.
  - RUN -> FLUSH when ap_start[c]=0.
  - FLUSH:
    - leaf_out_ready=0.
    - Inbound delivery and outbound replay continue.
    - -> IDLE when FIFO empty and replay empty.
    - -> RUN if ap_start returns to 1 first.
- Reset mid-operation discards all buffered and replay packets without emitting them.

Test Plan:
- Reset, then 3 inbound packets on ch0 in IDLE -> no leaf_in valid; ap_start[0]=1 -> 3 packets delivered in order, one per cycle with leaf_in_ready=1.
- 10 back-to-back inbound packets on ch1, leaf_in_ready=0, FIFO_DEPTH=8 -> 8 stored; resend_to_bft[1] pulses 1 cycle after packets 9 and 10; drop_cnt[1]=2.
- Full FIFO with simultaneous pop and push -> no resend; count remains 8; order preserved.
- Leaf offers packet 0x1_0000_0000_ABCD on ch2; resend_from_bft=1 in the first V cycle -> identical packet re-presented; resend=0 -> leaf_out_ready=1 in that V cycle.
- ap_start[3] dropped with 2 packets in the FIFO -> run_state=FLUSH; both delivered; then IDLE; leaf_out_ready stays 0 throughout.
- reset_n asserted mid-replay -> dout 0 immediately (async); after release, state IDLE and drop_cnt 0.
